// File: rtl/ysyx_22041211_imm_stage.sv
// ysyx_22041211_imm_stage: buffered RV immediate generator feeding execute through a DEPTH-entry FIFO
module ysyx_22041211_imm_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_imm,
  output logic [2:0]             out_type,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]     imm32;
  logic [2:0]      typ;
  logic [XLEN-1:0] imm;
  logic            s;
  logic            enq, deq;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] imm_q  [DEPTH];
  logic [2:0]      typ_q  [DEPTH];
  assign s = in_inst[31];
  // Classify by opcode and build a 32-bit immediate; zimm has bit 31 clear so widening by sign is safe
  always_comb begin
    typ   = 3'd7;
    imm32 = '0;
    case (in_inst[6:0])
      7'b0110011: typ = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        typ   = 3'd1;
        imm32 = {{20{s}}, in_inst[31:20]};
      end
      7'b1110011: begin
        typ   = in_inst[14] ? 3'd6 : 3'd1;
        imm32 = in_inst[14] ? {27'b0, in_inst[19:15]} : {{20{s}}, in_inst[31:20]};
      end
      7'b0100011: begin
        typ   = 3'd2;
        imm32 = {{20{s}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        typ   = 3'd3;
        imm32 = {{20{s}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        typ   = 3'd4;
        imm32 = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        typ   = 3'd5;
        imm32 = {{12{s}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      default: typ = 3'd7;
    endcase
  end
  assign imm       = XLEN'($signed(imm32));
  assign in_ready  = cnt_q != CW'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;
  // Next-state for pointers and occupancy; flush clears everything and ignores both handshakes
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + AW'(enq);
    rptr_d = flush ? '0 : rptr_q + AW'(deq);
    cnt_d  = flush ? '0 : cnt_q + CW'(enq) - CW'(deq);
  end
  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  // Entry storage; contents are masked at the output when empty so no reset is needed
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[wptr_q] <= in_inst;
      pc_q[wptr_q]   <= in_pc;
      imm_q[wptr_q]  <= imm;
      typ_q[wptr_q]  <= typ;
    end
  end
  assign out_inst    = out_valid ? inst_q[rptr_q] : '0;
  assign out_pc      = out_valid ? pc_q[rptr_q] : '0;
  assign out_imm     = out_valid ? imm_q[rptr_q] : '0;
  assign out_type    = out_valid ? typ_q[rptr_q] : '0;
  assign out_illegal = out_valid && typ_q[rptr_q] == 3'd7;
  assign count       = cnt_q;
endmodule

// File: doc/ysyx_22041211_imm_stage.md
# ysyx_22041211_imm_stage

Parametrised, buffered immediate-generation stage for the NPC decode path. It accepts 32-bit RV instructions with their PC over a valid/ready handshake. At enqueue it classifies the format, builds the sign- or zero-extended immediate at XLEN width, and queues the results in a DEPTH-entry FIFO feeding execute. Relative to the earlier purely combinational generator it adds: XLEN generalisation, CSR zimm format, an illegal-opcode flag, backpressure buffering and flush.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all queued entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_inst  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_imm  out  XLEN  head immediate.
- out_type  out  3  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 illegal.
- out_illegal  out  1  head opcode unsupported.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Classification by opcode inst[6:0]:
  - 0110011 → R, imm=0.
  - 0010011, 0000011, 1100111 → I, sext(inst[31:20]).
  - 1110011: funct3[2]=1 → Z, zext(inst[19:15]); otherwise I, sext(inst[31:20]) (ecall/ebreak/csrrw/csrrs/csrrc).
  - 0100011 → S, sext({inst[31:25],inst[11:7]}).
  - 1100011 → B, sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - 0110111, 0010111 → U, sext({inst[31:12],12'b0}); bit 31 is replicated to XLEN.
  - 1101111 → J, sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - Any other opcode, or inst[1:0]≠11 → type 7, imm=0, illegal=1.
- All sign extension replicates inst[31] up to XLEN.
- The immediate is computed combinationally from in_inst and stored with inst/pc/type/illegal.
- FIFO:
  - Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is held separately, range 0..DEPTH.
  - Enqueue when in_valid && in_ready && !flush.
  - Dequeue when out_valid && out_ready && !flush.
- in_ready = (count≠DEPTH). When full, there is no pass-through even if out_ready=1 that cycle; in_ready rises the cycle after a dequeue.
- Simultaneous enqueue and dequeue with 0<count<DEPTH: count unchanged, both pointers advance.
- out_valid = (count≠0). When empty, out_inst/out_pc/out_imm/out_type/out_illegal are forced to 0.
- flush: next cycle count=0 and pointers=0. Any in_valid and out_ready handshake in the flush cycle is ignored; the upstream must re-present the instruction.
- An illegal instruction is queued like any other; the stage never stalls on it.

## Timing
- Reset values, the cycle after rst=1: count=0, both pointers=0, out_valid=0, all out_* data=0, in_ready=1. rst overrides flush and any handshakes in the same cycle.
- Reset mid-operation: all queued entries are lost; no partial outputs.
- Latency: an enqueue at edge N gives out_valid=1 with that entry's data after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Head outputs are stable while out_valid && !out_ready.
- Ordering is strict FIFO; no reordering and no drops except on flush or reset.
- Wrap-around: after DEPTH enqueues the write pointer returns to 0. Data integrity must hold across repeated wrap.

## Test plan
- XLEN=32, one instruction at a time, out_ready=1:
  - 0xfff00093 (addi -1) → type 1, imm 0xffffffff, one cycle after enqueue.
  - 0x123450b7 (lui) → type 4, imm 0x12345000.
  - 0xffdff06f (jal -4) → type 5, imm 0xfffffffc.
  - 0xfe000ee3 (beq -4) → type 3, imm 0xfffffffc.
- XLEN=64:
  - 0x800000b7 (lui 0x80000) → imm 0xffffffff80000000.
  - 0x3002d073 (csrrwi x0,mstatus,5) → type 6, imm 5.
  - 0x00000000 → type 7, illegal=1, imm 0.
- DEPTH=4, out_ready=0, 5 back-to-back pushes:
  - in_ready falls after the 4th push; count=4; the 5th is not accepted.
  - Raise out_ready: outputs drain in push order, and in_ready returns the cycle after the first pop.
- Continuous push and pop for 3×DEPTH instructions with random out_ready stalls: output sequence equals input sequence; count never exceeds DEPTH.
- Queue 3 entries, then assert flush together with in_valid=1 and out_ready=1: next cycle count=0, out_valid=0, and neither the flush-cycle input nor the head pop takes effect.
- Assert rst mid-stream with count=2: next cycle count=0, out_valid=0, in_ready=1, all out_* data=0.
